// File: rtl/scc_dump_pkg.sv
// Shared types and constants for the post-halt memory dump streamer.
package scc_dump_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dump_state_e;

    // Byte stride between consecutive dumped words.
    localparam int unsigned WORD_BYTES = 4;

    localparam int unsigned REC_ADDR_W = 32;
    localparam int unsigned REC_DATA_W = 32;

    // One dump record as seen on the output stream.
    typedef struct packed {
        logic [REC_ADDR_W-1:0] addr;
        logic [REC_DATA_W-1:0] data;
        logic                  last;
    } dump_rec_t;

endpackage

// File: rtl/dump_fifo.sv
// Two-entry synchronous FIFO; all state advances only on enabled cycles.
module dump_fifo #(
    parameter int unsigned WIDTH = 65
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clk_en,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    // Storage, pointers and occupancy; push and pop may coincide.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_clk_en) begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/mem_dump_streamer.sv
// Walks data memory after halt and streams one (address, value) record per word.
module mem_dump_streamer
    import scc_dump_pkg::*;
#(
    parameter int unsigned      ADDR_W    = 32,
    parameter int unsigned      DATA_W    = 32,
    parameter int unsigned      NUM_WORDS = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clk_en,
    input  logic              i_start,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_rd_addr,
    input  logic [DATA_W-1:0] i_mem_rd_data,
    output logic              o_rec_valid,
    input  logic              i_rec_ready,
    output logic [ADDR_W-1:0] o_rec_addr,
    output logic [DATA_W-1:0] o_rec_data,
    output logic              o_rec_last,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned IDX_W = $clog2(NUM_WORDS + 1);
    localparam int unsigned REC_W = ADDR_W + DATA_W + 1;

    dump_state_e       r_state;
    dump_state_e       w_state_nxt;
    logic              r_start_q;
    logic [IDX_W-1:0]  r_idx;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_addr;
    logic              r_inflight_last;

    logic              w_start_edge;
    logic              w_go;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [1:0]        w_count;
    logic [2:0]        w_pending;
    logic [REC_W-1:0]  w_head;

    assign w_start_edge = i_start && !r_start_q;
    assign w_count      = w_full ? 2'd2 : {1'b0, !w_empty};
    assign w_pop        = o_rec_valid && i_rec_ready;

    // A slot freed by this cycle's pop counts as credit, so a steady ready
    // sink sees one record per cycle without ever overrunning the FIFO.
    assign w_pending    = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue      = (r_state == RUN) && (r_idx < IDX_W'(NUM_WORDS))
                          && (w_pending < 3'd2);
    assign w_issue_last = (r_idx == IDX_W'(NUM_WORDS - 1));

    assign o_mem_rd_en   = w_issue;
    assign o_mem_rd_addr = BASE_ADDR + ADDR_W'(r_idx) * ADDR_W'(WORD_BYTES);

    // Next-state: start edges are only honoured outside RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                if (w_start_edge) begin
                    w_state_nxt = RUN;
                    w_go        = 1'b1;
                end
            end
            RUN: begin
                if (w_pop && o_rec_last) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, start edge detector, issue index and the single in-flight read.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= IDLE;
            r_start_q       <= 1'b0;
            r_idx           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
            r_inflight_last <= 1'b0;
        end else if (i_clk_en) begin
            r_state    <= w_state_nxt;
            r_start_q  <= i_start;
            r_inflight <= w_issue;
            if (w_go) begin
                r_idx <= '0;
            end else if (w_issue) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if (w_issue) begin
                r_inflight_addr <= o_mem_rd_addr;
                r_inflight_last <= w_issue_last;
            end
        end
    end

    dump_fifo #(
        .WIDTH (REC_W)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clk_en (i_clk_en),
        .i_push   (r_inflight),
        .i_pop    (w_pop),
        .i_wdata  ({r_inflight_addr, i_mem_rd_data, r_inflight_last}),
        .o_rdata  (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    assign o_rec_valid = !w_empty;
    assign o_rec_addr  = w_head[REC_W-1 -: ADDR_W];
    assign o_rec_data  = w_head[DATA_W:1];
    assign o_rec_last  = w_head[0];
    assign o_busy      = (r_state == RUN);
    assign o_done      = (r_state == DONE);

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Directed bench for mem_dump_streamer: table of expected records plus
// hand-written sequences for backpressure, gating, start and reset corners.
module tb_mem_dump_streamer;
    import scc_dump_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clk_en, start, rec_ready;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data = '0;
    logic        rec_valid, rec_last, busy, done;
    logic [31:0] rec_addr, rec_data;

    logic        start1;
    logic        ready1 = 1'b1;
    logic        s1_rd_en, s1_valid, s1_last, s1_busy, s1_done;
    logic [31:0] s1_rd_addr, s1_addr, s1_data;
    logic [31:0] s1_rd_data = '0;

    int n_vec  = 0;
    int n_fail = 0;

    logic [31:0] mem0 [6];
    dump_rec_t   exp_tab [6];

    typedef struct {
        int mode;  // 0 ready high, 1 ready 1,0,0 pattern, 2 clk_en gap, 3 start pulse in RUN
        int stop;
    } run_t;
    run_t runs [4];

    mem_dump_streamer #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .NUM_WORDS (6),
        .BASE_ADDR (32'h0000_0880)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_clk_en      (clk_en),
        .i_start       (start),
        .o_mem_rd_en   (mem_rd_en),
        .o_mem_rd_addr (mem_rd_addr),
        .i_mem_rd_data (mem_rd_data),
        .o_rec_valid   (rec_valid),
        .i_rec_ready   (rec_ready),
        .o_rec_addr    (rec_addr),
        .o_rec_data    (rec_data),
        .o_rec_last    (rec_last),
        .o_busy        (busy),
        .o_done        (done)
    );

    mem_dump_streamer #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .NUM_WORDS (1),
        .BASE_ADDR (32'h0000_0000)
    ) dut1 (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_clk_en      (clk_en),
        .i_start       (start1),
        .o_mem_rd_en   (s1_rd_en),
        .o_mem_rd_addr (s1_rd_addr),
        .i_mem_rd_data (s1_rd_data),
        .o_rec_valid   (s1_valid),
        .i_rec_ready   (ready1),
        .o_rec_addr    (s1_addr),
        .o_rec_data    (s1_data),
        .o_rec_last    (s1_last),
        .o_busy        (s1_busy),
        .o_done        (s1_done)
    );

    function automatic logic [31:0] rd0(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'h880;
        if (off < 32'd24 && off[1:0] == 2'b00) return mem0[off[4:2]];
        return 32'hBAD0_BAD0;
    endfunction

    // Memory models: one-enabled-cycle read latency.
    always @(posedge clk) begin
        if (clk_en && mem_rd_en) mem_rd_data <= rd0(mem_rd_addr);
        if (clk_en && s1_rd_en)
            s1_rd_data <= (s1_rd_addr == 32'h0) ? 32'hDEAD_BEEF : 32'hBAD0_BAD0;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic run_dump(input int mode, input int stop);
        int k, c, it, first_v, issued, gaps;
        logic pv, px, pen, pbusy, prd, pl, xfer;
        logic [31:0] pa, pd;
        k = 0; c = 0; it = 0; first_v = -1; issued = 0; gaps = 0;
        pv = 1'b0; px = 1'b0; pen = 1'b1; pbusy = 1'b0; prd = 1'b0; pl = 1'b0;
        pa = '0; pd = '0;
        @(posedge clk); #1 start = 1'b1;
        while (k < stop && it < 300) begin
            @(posedge clk); #1;
            rec_ready = (mode == 1) ? (c % 3 == 0) : 1'b1;
            clk_en    = 1'b1;
            if (mode == 2 && c == 4 && gaps < 5) begin
                clk_en = 1'b0;
                gaps++;
            end
            if (mode == 3 && c == 3) start = 1'b0;
            if (mode == 3 && c == 4) start = 1'b1;
            @(negedge clk);
            xfer = rec_valid && rec_ready && clk_en;
            if (pv && !px) begin
                chk("hold_valid", rec_valid, 1);
                chk("hold_addr", rec_addr, pa);
                chk("hold_data", rec_data, pd);
                chk("hold_last", rec_last, pl);
            end
            if (!pen) begin
                chk("gap_busy", busy, pbusy);
                chk("gap_rd_en", mem_rd_en, prd);
            end
            if (rec_valid && first_v < 0) first_v = c;
            if (clk_en && mem_rd_en) begin
                chk("credit", ((issued - k - (xfer ? 1 : 0)) < 2), 1);
                chk("rd_addr", mem_rd_addr, 32'h880 + 4 * issued);
                issued++;
            end
            if (xfer) begin
                chk("rec_addr", rec_addr, exp_tab[k].addr);
                chk("rec_data", rec_data, exp_tab[k].data);
                chk("rec_last", rec_last, exp_tab[k].last);
                k++;
            end
            pv = rec_valid; px = xfer; pen = clk_en; pbusy = busy; prd = mem_rd_en;
            pa = rec_addr; pd = rec_data; pl = rec_last;
            if (clk_en) c++;
            it++;
        end
        chk("rec_count", k, stop);
        if (mode == 0) chk("latency", first_v, 2);
        if (stop == 6) begin
            chk("issued", issued, 6);
            @(posedge clk); #1;
            @(negedge clk);
            chk("done_after", done, 1);
            chk("busy_after", busy, 0);
            chk("valid_after", rec_valid, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic got;
        mem0[0] = 32'h0000_0010; mem0[1] = 32'h0000_0010;
        mem0[2] = 32'h0010_0010; mem0[3] = 32'h0f0f_0f0f;
        mem0[4] = 32'h0000_0100; mem0[5] = 32'h0000_0100;
        exp_tab[0] = '{addr: 32'h880, data: 32'h0000_0010, last: 1'b0};
        exp_tab[1] = '{addr: 32'h884, data: 32'h0000_0010, last: 1'b0};
        exp_tab[2] = '{addr: 32'h888, data: 32'h0010_0010, last: 1'b0};
        exp_tab[3] = '{addr: 32'h88c, data: 32'h0f0f_0f0f, last: 1'b0};
        exp_tab[4] = '{addr: 32'h890, data: 32'h0000_0100, last: 1'b0};
        exp_tab[5] = '{addr: 32'h894, data: 32'h0000_0100, last: 1'b1};
        runs[0] = '{mode: 0, stop: 6};
        runs[1] = '{mode: 1, stop: 6};
        runs[2] = '{mode: 2, stop: 6};
        runs[3] = '{mode: 3, stop: 6};

        rst = 1'b1; clk_en = 1'b1; start = 1'b0; rec_ready = 1'b0; start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", rec_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", rec_addr, 0);
        chk("rst_data", rec_data, 0);
        chk("rst_last", rec_last, 0);
        chk("rst1_valid", s1_valid, 0);
        chk("rst1_busy", s1_busy, 0);

        for (int i = 0; i < 4; i++) begin
            run_dump(runs[i].mode, runs[i].stop);
            // start stays high: a sticky level must not re-trigger
            repeat (4) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("hold_done", done, 1);
                chk("hold_busy", busy, 0);
                chk("hold_rd_en", mem_rd_en, 0);
            end
            @(posedge clk); #1 start = 1'b0;
        end

        // Reset with the third record at the head of the stream
        run_dump(0, 2);
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", rec_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_rd_en", mem_rd_en, 0);
        run_dump(0, 6);
        @(posedge clk); #1 start = 1'b0;

        // Single-word dump
        @(posedge clk); #1 start1 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && got == 1'b0; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (s1_valid) begin
                chk("n1_addr", s1_addr, 32'h0);
                chk("n1_data", s1_data, 32'hDEAD_BEEF);
                chk("n1_last", s1_last, 1);
                got = 1'b1;
            end
        end
        chk("n1_got", got, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("n1_done", s1_done, 1);
        chk("n1_busy", s1_busy, 0);
        chk("n1_valid", s1_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
